// File: rtl/absorb_pad_stage_if.sv
// rtl/absorb_pad_stage_if.sv - word-in / padded-block-out bundle for absorb_pad_stage
interface absorb_pad_stage_if #(
    parameter int w    = 64,
    parameter int RATE = 1344
);
    logic [w-1:0]    data_in;
    logic            valid_in;
    logic            ready_in;
    logic            last_in;
    logic [3:0]      last_bytes_in;
    logic [RATE-1:0] rate_output;
    logic [1:0]      operation_mode_out;
    logic [31:0]     output_size_out;
    logic            block_valid;
    logic            block_ready;
    logic            first_block;
    logic            last_block;
    logic            error_out;

    modport slave (
        input  data_in, valid_in, last_in, last_bytes_in, block_ready,
        output ready_in, rate_output, operation_mode_out, output_size_out,
               block_valid, first_block, last_block, error_out
    );

    modport master (
        output data_in, valid_in, last_in, last_bytes_in, block_ready,
        input  ready_in, rate_output, operation_mode_out, output_size_out,
               block_valid, first_block, last_block, error_out
    );
endinterface

// File: rtl/absorb_pad_stage.sv
// rtl/absorb_pad_stage.sv - packs a header plus 64-bit message words into SHAKE-padded rate blocks
// Build macro ABSORB_PAD_MODE_CHECK_EN: reject unknown header modes and drain their message words
module absorb_pad_stage #(
    parameter int w    = 64,
    parameter int RATE = 1344
) (
    input logic               clk,
    input logic               rst,
    absorb_pad_stage_if.slave bus
);
    localparam int          LANES             = RATE / w;
    localparam logic [1:0]  SHAKE128_MODE_VEC = 2'b00;
    localparam logic [1:0]  SHAKE256_MODE_VEC = 2'b01;
    localparam logic [63:0] PAD_LAST          = 64'h8000_0000_0000_0000;
    localparam logic [63:0] PAD_FIRST         = 64'h0000_0000_0000_001F;

    typedef enum logic [2:0] {
        HEADER,
        ABSORB,
        EMIT,
        PADBLK
`ifdef ABSORB_PAD_MODE_CHECK_EN
        , DRAIN
`endif
    } state_t;

    state_t       state_q, state_d;
    logic [w-1:0] lanes [LANES];
    logic [4:0]   cnt, cnt_nx, fin;
    logic         pad_pending, last_q, first_q;
    logic [1:0]   mode_q;
    logic [31:0]  size_q;
    logic [3:0]   n_eff;
    logic [w-1:0] pad_word;
    logic         in_fire, blk_fire;

`ifdef ABSORB_PAD_MODE_CHECK_EN
    logic err_q, hdr_bad;
    assign hdr_bad = (bus.data_in[1:0] != SHAKE128_MODE_VEC) &&
                     (bus.data_in[1:0] != SHAKE256_MODE_VEC);
    assign bus.ready_in  = (state_q == HEADER) || (state_q == ABSORB) || (state_q == DRAIN);
    assign bus.error_out = err_q;
`else
    assign bus.ready_in  = (state_q == HEADER) || (state_q == ABSORB);
    assign bus.error_out = 1'b0;
`endif

    assign in_fire  = bus.valid_in && bus.ready_in;
    assign blk_fire = bus.block_valid && bus.block_ready;
    assign fin      = (mode_q == SHAKE256_MODE_VEC) ? 5'd16 : 5'(LANES - 1);
    assign cnt_nx   = cnt + 5'd1;
    assign n_eff    = (bus.last_bytes_in > 4'd8) ? 4'd8 : bus.last_bytes_in;

    // Final-word image: keep the first n bytes, domain byte 0x1F right after them
    always_comb begin
        pad_word = '0;
        for (int j = 0; j < 8; j++) begin
            if (4'(j) < n_eff)
                pad_word[8*j +: 8] = bus.data_in[8*j +: 8];
            else if (4'(j) == n_eff)
                pad_word[8*j +: 8] = 8'h1F;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= HEADER;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HEADER: begin
`ifdef ABSORB_PAD_MODE_CHECK_EN
                if (in_fire) state_d = hdr_bad ? DRAIN : ABSORB;
`else
                if (in_fire) state_d = ABSORB;
`endif
            end
            ABSORB: if (in_fire && (bus.last_in || cnt == fin)) state_d = EMIT;
            EMIT: begin
                if (blk_fire) begin
                    if (pad_pending)  state_d = PADBLK;
                    else if (last_q)  state_d = HEADER;
                    else              state_d = ABSORB;
                end
            end
            PADBLK: state_d = EMIT;
`ifdef ABSORB_PAD_MODE_CHECK_EN
            DRAIN: if (in_fire && bus.last_in) state_d = HEADER;
`endif
            default: state_d = HEADER;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) lanes[i] <= '0;
            cnt         <= '0;
            pad_pending <= 1'b0;
            last_q      <= 1'b0;
            first_q     <= 1'b0;
            mode_q      <= '0;
            size_q      <= '0;
`ifdef ABSORB_PAD_MODE_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                HEADER: if (in_fire) begin
                    for (int i = 0; i < LANES; i++) lanes[i] <= '0;
                    mode_q      <= bus.data_in[1:0];
                    size_q      <= bus.data_in[63:32];
                    cnt         <= '0;
                    first_q     <= 1'b1;
                    last_q      <= 1'b0;
                    pad_pending <= 1'b0;
`ifdef ABSORB_PAD_MODE_CHECK_EN
                    err_q       <= hdr_bad;
`endif
                end
                ABSORB: if (in_fire) begin
                    if (!bus.last_in) begin
                        lanes[cnt] <= bus.data_in;
                        cnt        <= cnt_nx;
                    end else if (n_eff < 4'd8) begin
                        if (cnt == fin) begin
                            lanes[cnt] <= pad_word | PAD_LAST;
                        end else begin
                            lanes[cnt] <= pad_word;
                            lanes[fin] <= PAD_LAST;
                        end
                        last_q <= 1'b1;
                    end else if (cnt == fin) begin
                        // Full final word fills the block: padding needs a block of its own
                        lanes[cnt]  <= bus.data_in;
                        pad_pending <= 1'b1;
                    end else begin
                        lanes[cnt] <= bus.data_in;
                        if (cnt_nx == fin) begin
                            lanes[fin] <= PAD_LAST | PAD_FIRST;
                        end else begin
                            lanes[cnt_nx] <= PAD_FIRST;
                            lanes[fin]    <= PAD_LAST;
                        end
                        last_q <= 1'b1;
                    end
                end
                EMIT: if (blk_fire) begin
                    for (int i = 0; i < LANES; i++) lanes[i] <= '0;
                    cnt         <= '0;
                    first_q     <= 1'b0;
                    pad_pending <= 1'b0;
                end
                PADBLK: begin
                    lanes[0]   <= PAD_FIRST;
                    lanes[fin] <= PAD_LAST;
                    last_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign bus.rate_output[RATE-1-w*k -: w] = lanes[k];
    end

    assign bus.block_valid        = (state_q == EMIT);
    assign bus.first_block        = bus.block_valid && first_q;
    assign bus.last_block         = bus.block_valid && last_q;
    assign bus.operation_mode_out = mode_q;
    assign bus.output_size_out    = size_q;
endmodule

// File: tb/tb_absorb_pad_stage.sv
// tb/tb_absorb_pad_stage.sv - randomized bench for absorb_pad_stage against a byte-level sponge padding model
module tb_absorb_pad_stage;
    localparam int RATE = 1344;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    absorb_pad_stage_if #(.w(64), .RATE(RATE)) bus();
    absorb_pad_stage #(.w(64), .RATE(RATE)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    bit timed_out;

    byte unsigned    msg_q[$];
    logic [RATE-1:0] exp_blk[$], obs_blk[$];
    logic            exp_first[$], obs_first[$], exp_last[$], obs_last[$];

    always @(negedge clk) begin
        if (bus.block_valid && bus.block_ready) begin
            obs_blk.push_back(bus.rate_output);
            obs_first.push_back(bus.first_block);
            obs_last.push_back(bus.last_block);
        end
    end

    function automatic void make_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endfunction

    // Sponge padding on bytes: msg || 1F || 0* with 0x80 ORed into the last byte of the rate
    function automatic void build_model(input logic [1:0] mode);
        int rb;
        int nb;
        byte unsigned p[$];
        logic [RATE-1:0] blk;
        rb = (mode == 2'b01) ? 136 : 168;
        p = msg_q;
        p.push_back(8'h1F);
        while (p.size() % rb != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        nb = p.size() / rb;
        exp_blk.delete(); exp_first.delete(); exp_last.delete();
        for (int b = 0; b < nb; b++) begin
            blk = '0;
            for (int i = 0; i < rb; i++) blk[1280 - 64*(i/8) + 8*(i%8) +: 8] = p[b*rb + i];
            exp_blk.push_back(blk);
            exp_first.push_back(b == 0);
            exp_last.push_back(b == nb - 1);
        end
    endfunction

    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int t;
        t = 0;
        bus.data_in = d; bus.last_in = last; bus.last_bytes_in = nb; bus.valid_in = 1'b1;
        while (!bus.ready_in && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) timed_out = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic run_msg(input logic [1:0] mode, input logic [31:0] size, input bit extra_empty);
        int len, q, r, nw, nb, t;
        bit lst;
        logic [63:0] d;
        len = msg_q.size(); q = len / 8; r = len % 8;
        nw = (r != 0 || len == 0 || extra_empty) ? q + 1 : q;
        timed_out = 1'b0;
        obs_blk.delete(); obs_first.delete(); obs_last.delete();
        send_word({size, 30'($urandom), mode}, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 8)));
        for (int i = 0; i < nw; i++) begin
            lst = (i == nw - 1);
            nb  = !lst ? 8 : (r != 0) ? r : (len == 0 || extra_empty) ? 0 : 8;
            d   = {$urandom, $urandom};
            for (int j = 0; j < nb; j++) d[8*j +: 8] = msg_q[8*i + j];
            send_word(d, lst, 4'(nb));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(bus.ready_in && !bus.block_valid) && t < 500);
        if (t >= 500) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.ready_in !== 1'b1 || bus.block_valid !== 1'b0) begin
            bad++; $display("FAIL reset_handshake actual=%b%b required=10", bus.ready_in, bus.block_valid);
        end
        total++;
        if (bus.rate_output !== '0) begin bad++; $display("FAIL reset_rate actual=%h required=0", bus.rate_output); end
        total++;
        if ({bus.operation_mode_out, bus.output_size_out, bus.first_block, bus.last_block, bus.error_out} !== '0) begin
            bad++; $display("FAIL reset_flags actual=%h/%h/%b%b%b required=0", bus.operation_mode_out,
                            bus.output_size_out, bus.first_block, bus.last_block, bus.error_out);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.ready_in !== 1'b1) begin bad++; $display("FAIL post_reset_ready actual=%b required=1", bus.ready_in); end
    endtask

    task automatic test_padding_cases();
        int         lens[5]  = '{0, 135, 136, 160, 7};
        logic [1:0] modes[5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
        logic [31:0] size;
        for (int c = 0; c < 5; c++) begin
            size = (c == 0) ? 32'd256 : $urandom;
            make_msg(lens[c]);
            build_model(modes[c]);
            run_msg(modes[c], size, 1'b0);
            total++;
            if (timed_out) begin bad++; $display("FAIL pad%0d_timeout actual=stuck required=done", c); end
            total++;
            if (obs_blk.size() != exp_blk.size()) begin
                bad++; $display("FAIL pad%0d_blocks actual=%0d required=%0d", c, obs_blk.size(), exp_blk.size());
            end else begin
                for (int b = 0; b < exp_blk.size(); b++) begin
                    total++;
                    if (obs_blk[b] !== exp_blk[b]) begin
                        bad++; $display("FAIL pad%0d_rate%0d actual=%h required=%h", c, b, obs_blk[b], exp_blk[b]);
                    end
                    total++;
                    if ({obs_first[b], obs_last[b]} !== {exp_first[b], exp_last[b]}) begin
                        bad++; $display("FAIL pad%0d_flags%0d actual=%b%b required=%b%b", c, b,
                                        obs_first[b], obs_last[b], exp_first[b], exp_last[b]);
                    end
                end
            end
            total++;
            if (bus.output_size_out !== size || bus.operation_mode_out !== modes[c]) begin
                bad++; $display("FAIL pad%0d_header actual=%0d/%0d required=%0d/%0d", c,
                                bus.output_size_out, bus.operation_mode_out, size, modes[c]);
            end
            if (c == 0 && obs_blk.size() == 1) begin
                total++;
                if (obs_blk[0][1343 -: 64] !== 64'h1F || obs_blk[0][63:0] !== 64'h8000_0000_0000_0000) begin
                    bad++; $display("FAIL empty_lanes actual=%h/%h required=1f/8000000000000000",
                                    obs_blk[0][1343 -: 64], obs_blk[0][63:0]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] mode;
        for (int c = 0; c < 8; c++) begin
            mode = 2'($urandom_range(0, 1));
            make_msg($urandom_range(0, 350));
            build_model(mode);
            run_msg(mode, $urandom, 1'($urandom_range(0, 1)));
            total++;
            if (timed_out) begin bad++; $display("FAIL rnd%0d_timeout actual=stuck required=done", c); end
            total++;
            if (obs_blk.size() != exp_blk.size()) begin
                bad++; $display("FAIL rnd%0d_blocks actual=%0d required=%0d", c, obs_blk.size(), exp_blk.size());
            end else begin
                for (int b = 0; b < exp_blk.size(); b++) begin
                    total++;
                    if (obs_blk[b] !== exp_blk[b] || {obs_first[b], obs_last[b]} !== {exp_first[b], exp_last[b]}) begin
                        bad++; $display("FAIL rnd%0d_blk%0d actual=%h/%b%b required=%h/%b%b", c, b, obs_blk[b],
                                        obs_first[b], obs_last[b], exp_blk[b], exp_first[b], exp_last[b]);
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        make_msg(171);
        build_model(2'b00);
        bus.block_ready = 1'b0;
        fork
            run_msg(2'b00, 32'd1344, 1'b0);
            begin : stall_branch
                int t;
                logic [RATE-1:0] snap;
                t = 0;
                while (!bus.block_valid && t < 1000) begin @(negedge clk); t++; end
                total++;
                if (bus.block_valid !== 1'b1) begin bad++; $display("FAIL stall_wait actual=0 required=1"); end
                snap = bus.rate_output;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    total++;
                    if (bus.rate_output !== snap || bus.ready_in !== 1'b0 || bus.block_valid !== 1'b1) begin
                        bad++; $display("FAIL stall_hold%0d actual=%b/%b/%b required=1/0/1", c,
                                        bus.rate_output === snap, bus.ready_in, bus.block_valid);
                    end
                end
                @(posedge clk); #1;
                bus.block_ready = 1'b1;
            end
        join
        total++;
        if (timed_out) begin bad++; $display("FAIL stall_timeout actual=stuck required=done"); end
        total++;
        if (obs_blk.size() != 2) begin
            bad++; $display("FAIL stall_blocks actual=%0d required=2", obs_blk.size());
        end else begin
            for (int b = 0; b < 2; b++) begin
                total++;
                if (obs_blk[b] !== exp_blk[b] || {obs_first[b], obs_last[b]} !== {exp_first[b], exp_last[b]}) begin
                    bad++; $display("FAIL stall_blk%0d actual=%h required=%h", b, obs_blk[b], exp_blk[b]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        timed_out = 1'b0;
        obs_blk.delete(); obs_first.delete(); obs_last.delete();
        send_word({32'd512, 30'd0, 2'b00}, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++) send_word({$urandom, $urandom} | 64'h1, 1'b0, 4'd8);
        #2; rst = 1'b0; #1;
        total++;
        if (bus.rate_output !== '0 || bus.ready_in !== 1'b1 || bus.block_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_async actual=%0d/%b/%b required=0/1/0",
                            bus.rate_output != '0, bus.ready_in, bus.block_valid);
        end
        total++;
        if ({bus.output_size_out, bus.operation_mode_out, bus.first_block, bus.last_block} !== '0) begin
            bad++; $display("FAIL rst_mid_flags actual=%h required=0", bus.output_size_out);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs_blk.size() != 0) begin bad++; $display("FAIL rst_mid_noblock actual=%0d required=0", obs_blk.size()); end
        make_msg($urandom_range(1, 200));
        build_model(2'b01);
        run_msg(2'b01, 32'd256, 1'b0);
        total++;
        if (timed_out || obs_blk.size() != exp_blk.size()) begin
            bad++; $display("FAIL rst_mid_after actual=%0d required=%0d", obs_blk.size(), exp_blk.size());
        end else begin
            for (int b = 0; b < exp_blk.size(); b++) begin
                total++;
                if (obs_blk[b] !== exp_blk[b]) begin
                    bad++; $display("FAIL rst_mid_blk%0d actual=%h required=%h", b, obs_blk[b], exp_blk[b]);
                end
            end
        end
    endtask

`ifdef ABSORB_PAD_MODE_CHECK_EN
    task automatic test_mode_check();
        timed_out = 1'b0;
        obs_blk.delete(); obs_first.delete(); obs_last.delete();
        send_word({32'd512, 30'd0, 2'b11}, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.error_out !== 1'b1 || bus.ready_in !== 1'b1 || bus.block_valid !== 1'b0) begin
                bad++; $display("FAIL drain%0d actual=%b%b%b required=110", i, bus.error_out, bus.ready_in, bus.block_valid);
            end
            send_word({$urandom, $urandom}, i == 2, 4'd5);
        end
        repeat (3) @(negedge clk);
        total++;
        if (obs_blk.size() != 0 || timed_out) begin bad++; $display("FAIL drain_noblock actual=%0d required=0", obs_blk.size()); end
        make_msg($urandom_range(0, 100));
        build_model(2'b00);
        run_msg(2'b00, 32'd128, 1'b0);
        total++;
        if (bus.error_out !== 1'b0) begin bad++; $display("FAIL drain_clear actual=%b required=0", bus.error_out); end
        total++;
        if (timed_out || obs_blk.size() != exp_blk.size() || obs_blk[0] !== exp_blk[0]) begin
            bad++; $display("FAIL drain_after actual=%0d required=%0d", obs_blk.size(), exp_blk.size());
        end
    endtask
`else
    task automatic test_unknown_mode();
        make_msg($urandom_range(100, 300));
        build_model(2'b10);
        run_msg(2'b10, 32'd64, 1'b0);
        total++;
        if (timed_out || obs_blk.size() != exp_blk.size()) begin
            bad++; $display("FAIL unk_blocks actual=%0d required=%0d", obs_blk.size(), exp_blk.size());
        end else begin
            for (int b = 0; b < exp_blk.size(); b++) begin
                total++;
                if (obs_blk[b] !== exp_blk[b]) begin
                    bad++; $display("FAIL unk_blk%0d actual=%h required=%h", b, obs_blk[b], exp_blk[b]);
                end
            end
        end
        total++;
        if (bus.error_out !== 1'b0) begin bad++; $display("FAIL unk_error actual=%b required=0", bus.error_out); end
    endtask
`endif

    initial begin
        bus.valid_in = 1'b0; bus.data_in = '0; bus.last_in = 1'b0;
        bus.last_bytes_in = '0; bus.block_ready = 1'b1;
        test_reset();
        test_padding_cases();
        test_random();
        test_stall();
        test_reset_mid();
`ifdef ABSORB_PAD_MODE_CHECK_EN
        test_mode_check();
`else
        test_unknown_mode();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
